// File: rtl/hex_entry_loader.sv
// hex_entry_loader: assembles keyed hex nibbles into a 16-bit word and writes it to memory over req/ack.
// Optional LOADER_TIMEOUT_EN: abandon an unacknowledged write after TIMEOUT cycles and raise sticky err.
module hex_entry_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              nib_tick,
    input  logic [3:0]        nib_val,
    input  logic              commit_tick,
    input  logic              clear_tick,
    input  logic              addr_load_tick,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    input  logic              wr_ack,
    output logic [15:0]       entry_word,
    output logic [2:0]        digit_cnt,
    output logic              busy,
    output logic              err
);
    typedef enum logic [1:0] {ENTRY, WRITE, WAIT_REL} state_t;
    state_t state, state_n;
    logic [15:0] entry_n, data_n;
    logic [2:0] cnt_n;
    logic [ADDR_W-1:0] addr_n;
    logic timeout;

    // wr_req/busy decode straight from state so an async reset drops them immediately
    assign wr_req = state == WRITE;
    assign busy   = wr_req;

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo;
    logic err_r;
    assign timeout = tmo == TW'(TIMEOUT - 1);
    assign err     = err_r;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo   <= '0;
            err_r <= 1'b0;
        end else begin
            tmo <= (state == WRITE) ? tmo + 1'b1 : '0;
            if (state == ENTRY && clear_tick)
                err_r <= 1'b0;
            else if (state == WRITE && !wr_ack && timeout)
                err_r <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ENTRY;
            entry_word <= '0;
            digit_cnt  <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            state      <= state_n;
            entry_word <= entry_n;
            digit_cnt  <= cnt_n;
            wr_addr    <= addr_n;
            wr_data    <= data_n;
        end
    end

    always_comb begin
        state_n = state;
        entry_n = entry_word;
        cnt_n   = digit_cnt;
        addr_n  = wr_addr;
        data_n  = wr_data;
        case (state)
            ENTRY: begin
                if (clear_tick) begin
                    entry_n = '0;
                    cnt_n   = '0;
                end else if (addr_load_tick) begin
                    addr_n  = entry_word[ADDR_W-1:0];
                    entry_n = '0;
                    cnt_n   = '0;
                end else if (commit_tick && digit_cnt != 3'd0) begin
                    data_n  = entry_word;
                    state_n = WRITE;
                end else if (nib_tick) begin
                    entry_n = {entry_word[11:0], nib_val};
                    cnt_n   = (digit_cnt == 3'd4) ? 3'd4 : digit_cnt + 3'd1;
                end
            end
            WRITE: begin
                if (wr_ack) begin
                    addr_n  = wr_addr + 1'b1;
                    entry_n = '0;
                    cnt_n   = '0;
                    state_n = WAIT_REL;
                end else if (timeout) begin
                    state_n = WAIT_REL;
                end
            end
            default: state_n = ENTRY;
        endcase
    end
endmodule

// File: tb/tb_hex_entry_loader.sv
// tb_hex_entry_loader: scoreboard bench for hex_entry_loader; timeout checks run when LOADER_TIMEOUT_EN is defined.
module tb_hex_entry_loader;
    logic clk = 1'b0, reset = 1'b1;
    logic nib_tick = 1'b0, commit_tick = 1'b0, clear_tick = 1'b0, addr_load_tick = 1'b0, wr_ack = 1'b0;
    logic [3:0] nib_val = 4'h0;
    logic wr_req, busy, err;
    logic [7:0] wr_addr;
    logic [15:0] wr_data, entry_word;
    logic [2:0] digit_cnt;
    logic [23:0] sb[$];
    logic [7:0] exp_addr = 8'h00;
    int total = 0, bad = 0;

    hex_entry_loader #(.ADDR_W(8), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .nib_tick(nib_tick), .nib_val(nib_val),
        .commit_tick(commit_tick), .clear_tick(clear_tick), .addr_load_tick(addr_load_tick),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .entry_word(entry_word), .digit_cnt(digit_cnt), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nib(input logic [3:0] v);
        nib_val  = v;
        nib_tick = 1'b1;
        step();
        nib_tick = 1'b0;
    endtask

    task automatic enter(input logic [15:0] w);
        for (int i = 3; i >= 0; i--) nib(w[i*4 +: 4]);
    endtask

    task automatic do_write(input logic [15:0] data, input int hold);
        logic [23:0] e;
        sb.push_back({exp_addr, data});
        commit_tick = 1'b1;
        step();
        commit_tick = 1'b0;
        chk("req_latency", wr_req, 1);
        chk("busy_write", busy, 1);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("req_hold", wr_req, 1);
            chk("addr_hold", wr_addr, exp_addr);
            chk("data_hold", wr_data, data);
        end
        wr_ack = 1'b1;
        e = sb.pop_front();
        chk("sb_addr", wr_addr, e[23:16]);
        chk("sb_data", wr_data, e[15:0]);
        step();
        wr_ack = 1'b0;
        exp_addr = exp_addr + 8'd1;
        chk("req_after_ack", wr_req, 0);
        chk("busy_after_ack", busy, 0);
        chk("addr_inc", wr_addr, exp_addr);
        chk("entry_cleared", entry_word, 0);
        chk("cnt_cleared", digit_cnt, 0);
        step();
    endtask

    initial begin
        repeat (2) step();
        reset = 1'b0;
        chk("rst_req", wr_req, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_entry", entry_word, 0);
        chk("rst_cnt", digit_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);

        enter(16'hABCD);
        chk("entry_abcd", entry_word, 16'hABCD);
        chk("cnt_4", digit_cnt, 4);
        nib(4'h1);
        chk("entry_shift", entry_word, 16'hBCD1);
        chk("cnt_sat", digit_cnt, 4);
        enter(16'hABCD);
        do_write(16'hABCD, 3);

        enter(16'h00FF);
        addr_load_tick = 1'b1;
        step();
        addr_load_tick = 1'b0;
        exp_addr = 8'hFF;
        chk("addr_load", wr_addr, 8'hFF);
        chk("addr_load_entry", entry_word, 0);
        enter(16'h1234);
        do_write(16'h1234, 0);
        chk("addr_wrap", wr_addr, 8'h00);

        commit_tick = 1'b1;
        step();
        commit_tick = 1'b0;
        chk("empty_commit", wr_req, 0);

        nib(4'h4);
        nib(4'h2);
        chk("entry_42", entry_word, 16'h0042);
        chk("cnt_2", digit_cnt, 2);
        clear_tick = 1'b1;
        commit_tick = 1'b1;
        step();
        clear_tick = 1'b0;
        commit_tick = 1'b0;
        chk("clr_commit_req", wr_req, 0);
        chk("clr_commit_entry", entry_word, 0);
        chk("clr_commit_cnt", digit_cnt, 0);

        nib(4'h5);
        nib(4'h6);
        commit_tick = 1'b1;
        step();
        commit_tick = 1'b0;
        chk("write_req", wr_req, 1);
        nib(4'h7);
        chk("nib_in_write", entry_word, 16'h0056);
        chk("write_data", wr_data, 16'h0056);
        wr_ack = 1'b1;
        step();
        wr_ack = 1'b0;
        chk("write_done_addr", wr_addr, 8'h01);
        step();

        nib(4'h9);
        commit_tick = 1'b1;
        step();
        commit_tick = 1'b0;
        chk("pre_rst_req", wr_req, 1);
        #1 reset = 1'b1;
        #1;
        chk("async_req", wr_req, 0);
        chk("async_addr", wr_addr, 0);
        chk("async_busy", busy, 0);
        chk("async_entry", entry_word, 0);
        step();
        reset = 1'b0;
        exp_addr = 8'h00;
        step();

`ifdef LOADER_TIMEOUT_EN
        begin
            int n = 0;
            nib(4'h7);
            nib(4'h7);
            commit_tick = 1'b1;
            step();
            commit_tick = 1'b0;
            while (wr_req && n < 20) begin
                n++;
                step();
            end
            chk("tmo_cycles", n, 8);
            chk("tmo_err", err, 1);
            chk("tmo_addr", wr_addr, 0);
            chk("tmo_entry", entry_word, 16'h0077);
            chk("tmo_cnt", digit_cnt, 2);
            step();
            clear_tick = 1'b1;
            step();
            clear_tick = 1'b0;
            chk("tmo_err_clr", err, 0);
        end
`endif

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
